// File: rtl/serial_negate_unit_pkg.sv
// Shared definitions for serial_negate_unit: operation mode encodings,
// FSM state encodings and small helpers that derive the per-operation
// invert flag and initial carry from the captured mode and operand sign.
package serial_negate_unit_pkg;

   typedef enum logic [1:0] {
      MODE_PASS = 2'b00,
      MODE_NEG  = 2'b01,
      MODE_ABS  = 2'b10,
      MODE_ONES = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_e;

   // Abs only inverts negative operands.
   function automatic logic inv_flag(mode_e m, logic msb);
      case (m)
         MODE_PASS: return 1'b0;
         MODE_ABS:  return msb;
         default:   return 1'b1;
      endcase
   endfunction

   // The +1 of two's complement enters as the initial carry.
   function automatic logic init_carry(mode_e m, logic msb);
      return (m == MODE_NEG) || ((m == MODE_ABS) && msb);
   endfunction

   function automatic logic can_ovf(mode_e m);
      return (m == MODE_NEG) || (m == MODE_ABS);
   endfunction

endpackage

// File: rtl/serial_negate_unit_if.sv
// Request/result bundle for serial_negate_unit.
//   start, mode, in : request (master drives)
//   out, busy, done, ovf, zero : result/status (slave drives)
interface serial_negate_unit_if #(parameter int WIDTH = 8);
   logic             start;
   logic [1:0]       mode;
   logic [WIDTH-1:0] in;
   logic [WIDTH-1:0] out;
   logic             busy;
   logic             done;
   logic             ovf;
   logic             zero;

   modport master (output start, mode, in,
                   input  out, busy, done, ovf, zero);
   modport slave  (input  start, mode, in,
                   output out, busy, done, ovf, zero);
endinterface

// File: rtl/serial_negate_unit_digit_adder.sv
// digit_adder: combinational DIGIT-bit increment-by-carry used once per
// serial step.
//   a_i    : DIGIT-bit operand digit (already conditionally inverted)
//   cin_i  : carry in from the previous digit
//   sum_o  : DIGIT-bit sum
//   cout_o : carry out to the next digit
module digit_adder #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a_i,
   input  logic             cin_i,
   output logic [DIGIT-1:0] sum_o,
   output logic             cout_o
);
   assign {cout_o, sum_o} = {1'b0, a_i} + (DIGIT+1)'(cin_i);
endmodule

// File: rtl/serial_negate_unit.sv
// serial_negate_unit: digit-serial pass / negate / abs / ones' complement.
// Processes DIGIT bits per cycle, LSB first; result digits enter the
// output register from the MSB end so the full word is aligned after
// WIDTH/DIGIT steps.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of serial_negate_unit_if (start/mode/in in,
//         out/busy/done/ovf/zero out)
module serial_negate_unit
   import serial_negate_unit_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input logic                clk,
   input logic                rst,
   serial_negate_unit_if.slave bus
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = $clog2(N) + 1;
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   generate
      if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_cfg
         $error("serial_negate_unit: WIDTH must be >=2 and a multiple of DIGIT");
      end
   endgenerate

   state_e           state_q;
   logic [WIDTH-1:0] shift_q, out_q, out_d;
   logic [CW-1:0]    cnt_q;
   logic             inv_q, carry_q, ovf_pend_q;
   logic             ovf_q, zero_q, busy_q, done_q;
   logic [DIGIT-1:0] sum;
   logic             cout;
   mode_e            mode_in;

   assign mode_in = mode_e'(bus.mode);

   digit_adder #(.DIGIT(DIGIT)) u_add (
      .a_i    (shift_q[DIGIT-1:0] ^ {DIGIT{inv_q}}),
      .cin_i  (carry_q),
      .sum_o  (sum),
      .cout_o (cout)
   );

   assign out_d = (out_q >> DIGIT) | (WIDTH'(sum) << (WIDTH - DIGIT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         out_q      <= '0;
         cnt_q      <= '0;
         inv_q      <= 1'b0;
         carry_q    <= 1'b0;
         ovf_pend_q <= 1'b0;
         ovf_q      <= 1'b0;
         zero_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  shift_q    <= bus.in;
                  inv_q      <= inv_flag(mode_in, bus.in[WIDTH-1]);
                  carry_q    <= init_carry(mode_in, bus.in[WIDTH-1]);
                  // Overflow depends only on the captured operand, so decide it now.
                  ovf_pend_q <= can_ovf(mode_in) && (bus.in == MOST_NEG);
                  cnt_q      <= '0;
                  ovf_q      <= 1'b0;
                  zero_q     <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= BUSY;
               end
            end
            BUSY: begin
               shift_q <= shift_q >> DIGIT;
               out_q   <= out_d;
               carry_q <= cout;   // final carry-out simply goes unused
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == CW'(N - 1)) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  ovf_q   <= ovf_pend_q;
                  zero_q  <= (out_d == '0);
                  state_q <= DONE;
               end
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.out  = out_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.ovf  = ovf_q;
   assign bus.zero = zero_q;

endmodule

// File: doc/serial_negate_unit.md
SERIAL_NEGATE_UNIT -- requirements
Module: serial_negate_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (>=2).
REQ-002 SHALL have parameter: DIGIT, 1, bits processed per cycle; WIDTH % DIGIT == 0 required, elaboration error otherwise.
REQ-003 One clock; reset is synchronous and active-high: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: mode  input  2  00 pass, 01 negate (two's complement), 10 absolute value, 11 ones' complement; sampled with start.
REQ-006 SHALL have port: in  input  WIDTH  operand; sampled with start.
REQ-007 SHALL have port: out  output  WIDTH  result register.
REQ-008 SHALL have port: busy  output  1  high while a conversion is in progress.
REQ-009 SHALL have port: done  output  1  single-cycle pulse when out is valid.
REQ-010 SHALL have port: ovf  output  1  result not representable (negate/abs of most-negative value); valid with done, held until next start.
REQ-011 SHALL have port: zero  output  1  out == 0; valid with done, held until next start.

Function
REQ-012 FSM states: IDLE, BUSY, DONE. IDLE->BUSY on start; BUSY->DONE after the last digit; DONE->IDLE unconditionally after one cycle.
REQ-013 On start in IDLE: capture in into shift register, capture mode, clear digit counter, set busy=1 next cycle.
REQ-014 Invert flag: pass 0, negate 1, abs = in[WIDTH-1], ones' 1. Initial carry: 1 iff mode is negate, or abs with in[WIDTH-1]=1; else 0.
REQ-015 Each BUSY cycle: take DIGIT LSBs of the shift register, XOR with invert flag, add carry register; DIGIT-bit sum shifts into out from the MSB end; carry-out stored for the next cycle.
REQ-016 Latency: done asserts exactly WIDTH/DIGIT+1 cycles after the cycle start is sampled (WIDTH/DIGIT BUSY cycles, then DONE).
REQ-017 done=1 only in DONE; busy=1 only in BUSY; out, ovf, zero stable from DONE until the next accepted start.
REQ-018 Final carry-out is discarded (modulo 2^WIDTH arithmetic).
REQ-019 ovf=1 iff mode in {negate, abs} and captured operand == 1 followed by WIDTH-1 zeros; out then equals the operand (0x80 for WIDTH=8); all other cases ovf=0.
REQ-020 Negate of 0 yields 0, zero=1, ovf=0.
REQ-021 start while busy or in DONE SHALL be ignored (no re-capture, no effect on current result).
REQ-022 start asserted in the same cycle DONE->IDLE occurs is ignored; accepted only when sampled in IDLE.
REQ-023 mode and in changes after capture SHALL not affect the ongoing conversion.

Reset
REQ-024 rst=1 at a rising clk edge: state IDLE, out=0, busy=0, done=0, ovf=0, zero=0, counter=0, carry=0; overrides start in the same cycle.
REQ-025 rst mid-conversion aborts it; no done pulse for the aborted operation; next start after reset release processes normally.

Structure
REQ-026 Shared package SHALL hold mode encodings (MODE_PASS, MODE_NEG, MODE_ABS, MODE_ONES) and FSM state encodings.
REQ-027 One sub-module digit_adder (combinational, DIGIT-bit a + cin -> sum, cout) SHALL perform per-cycle addition; counter, shift registers and FSM live in serial_negate_unit.
REQ-028 Counter width SHALL be $clog2(WIDTH/DIGIT)+1 bits; no other width-dependent hard-coded constants.

Verification
REQ-029 WIDTH=8, DIGIT=1: mode=01, in=0x05 -> done on 9th cycle after start, out=0xFB, ovf=0, zero=0; busy high 8 cycles.
REQ-030 WIDTH=8, DIGIT=1: mode=10, in=0x80 -> out=0x80, ovf=1; mode=10, in=0xF6 -> out=0x0A, ovf=0; mode=10, in=0x3C -> out=0x3C.
REQ-031 WIDTH=8, DIGIT=4: mode=01, in=0x01 -> done 3 cycles after start, out=0xFF; mode=01, in=0x00 -> out=0x00, zero=1.
REQ-032 WIDTH=8: mode=11, in=0xA5 -> out=0x5A; mode=00, in=0xA5 -> out=0xA5, ovf=0.
REQ-033 Start mode=01, in=0x05; 3 cycles later pulse start with in=0x7F -> out=0xFB, single done pulse; second start ignored.
REQ-034 Start mode=01, in=0x05; assert rst in cycle 4 -> busy=0, out=0, no done; after release start in=0x02 -> out=0xFE.
